// File: rtl/multi_pulse_counter.sv
// Multi-channel pulse-edge counter: synchronised inputs, selectable edge type, wrap/saturate, atomic snapshot.
// Optional threshold interrupt enabled by defining PULSE_CNT_THRESH_EN.
module multi_pulse_counter #(
  parameter int CH_NUM      = 4,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CH_NUM-1:0]       pulse,
  input  logic                    en,
  input  logic                    clr,
  input  logic [1:0]              edge_mode,
  input  logic                    sat_en,
  input  logic                    snap,
  output logic [CH_NUM*CNT_W-1:0] cnt,
  output logic [CH_NUM*CNT_W-1:0] snap_cnt,
  output logic                    snap_vld,
  output logic [CH_NUM-1:0]       ovf
`ifdef PULSE_CNT_THRESH_EN
  ,
  input  logic [CNT_W-1:0]        thresh,
  output logic [CH_NUM-1:0]       irq
`endif
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0][CH_NUM-1:0] sync_q, sync_d;
  logic [CH_NUM-1:0]                  hist_q, hist_d;
  logic [CH_NUM-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [CH_NUM-1:0][CNT_W-1:0]       snap_cnt_q, snap_cnt_d;
  logic                               snap_vld_q, snap_vld_d;
  logic [CH_NUM-1:0]                  ovf_q, ovf_d;
  logic [CH_NUM-1:0]                  s_w, rise_w, fall_w, both_w, hit_w;

  // Increment with overflow flag in the MSB; wrap or saturate at all-ones.
  function automatic logic [CNT_W:0] inc_cnt(input logic [CNT_W-1:0] v, input logic sat);
    logic [CNT_W-1:0] nxt;
    logic             of;
    of  = &v;
    nxt = v + ONE;
    if (of && sat) nxt = v;
    return {of, nxt};
  endfunction

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pulse};
    s_w    = sync_q[SYNC_STAGES-1];
    hist_d = s_w;
    rise_w = s_w & ~hist_q;
    fall_w = ~s_w & hist_q;
    both_w = s_w ^ hist_q;
    case (edge_mode)
      2'b00:   hit_w = rise_w;
      2'b01:   hit_w = fall_w;
      2'b10:   hit_w = both_w;
      default: hit_w = '0;
    endcase
  end

  always_comb begin
    logic [CNT_W:0] inc;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    inc   = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      inc = inc_cnt(cnt_q[i], sat_en);
      if (clr) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (en && hit_w[i]) begin
        cnt_d[i] = inc[CNT_W-1:0];
        if (inc[CNT_W]) ovf_d[i] = 1'b1;
      end
    end
  end

  // Snapshot captures the post-update value so a same-edge increment or clear is included.
  always_comb begin
    snap_cnt_d = snap_cnt_q;
    snap_vld_d = snap;
    if (snap) snap_cnt_d = cnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      hist_q     <= '0;
      cnt_q      <= '0;
      snap_cnt_q <= '0;
      snap_vld_q <= 1'b0;
      ovf_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      hist_q     <= hist_d;
      cnt_q      <= cnt_d;
      snap_cnt_q <= snap_cnt_d;
      snap_vld_q <= snap_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  assign cnt      = cnt_q;
  assign snap_cnt = snap_cnt_q;
  assign snap_vld = snap_vld_q;
  assign ovf      = ovf_q;

`ifdef PULSE_CNT_THRESH_EN
  logic [CH_NUM-1:0] irq_q, irq_d;

  // Fires only on the edge where the count changes onto thresh, not when thresh moves onto the count.
  always_comb begin
    irq_d = irq_q;
    for (int i = 0; i < CH_NUM; i++) begin
      if (clr) irq_d[i] = 1'b0;
      else if ((thresh != '0) && (cnt_d[i] == thresh) && (cnt_d[i] != cnt_q[i])) irq_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= '0;
    else        irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_multi_pulse_counter.sv
// Directed bench for multi_pulse_counter (CNT_W=4 so overflow is reachable); snapshot results via scoreboard queue.
module tb_multi_pulse_counter;
  localparam int CH = 4;
  localparam int W  = 4;
  localparam int SS = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CH-1:0]     pulse = '0;
  logic              en = 1'b0, clr = 1'b0, sat_en = 1'b0, snap = 1'b0;
  logic [1:0]        edge_mode = 2'b00;
  logic [CH*W-1:0]   cnt, snap_cnt;
  logic              snap_vld;
  logic [CH-1:0]     ovf;
`ifdef PULSE_CNT_THRESH_EN
  logic [W-1:0]      thresh = '0;
  logic [CH-1:0]     irq;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [CH*W-1:0] exp_q[$];

  multi_pulse_counter #(.CH_NUM(CH), .CNT_W(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .pulse(pulse), .en(en), .clr(clr),
    .edge_mode(edge_mode), .sat_en(sat_en), .snap(snap),
    .cnt(cnt), .snap_cnt(snap_cnt), .snap_vld(snap_vld), .ovf(ovf)
`ifdef PULSE_CNT_THRESH_EN
    , .thresh(thresh), .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ch_cnt(input int ch);
    return cnt[ch*W +: W];
  endfunction

  task automatic pulses(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      pulse[ch] = 1'b1;
      tick(2);
      pulse[ch] = 1'b0;
      tick(2);
    end
    tick(SS + 2);
  endtask

  // Waits (bounded) for snap_vld, then pops the oldest expected snapshot and compares.
  task automatic snap_check(input string tag);
    int waited;
    logic [CH*W-1:0] e;
    waited = 0;
    while (!snap_vld && waited < 8) begin
      tick(1);
      waited++;
    end
    chk({tag, "_vld_lat"}, 64'(waited), 64'(0));
    if (snap_vld && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, 64'(snap_cnt), 64'(e));
    end else begin
      chk({tag, "_seen"}, 64'(snap_vld), 64'(1));
    end
  endtask

  initial begin
    // reset state
    tick(3);
    chk("rst_cnt", 64'(cnt), 64'(0));
    chk("rst_snap_cnt", 64'(snap_cnt), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_snap_vld", 64'(snap_vld), 64'(0));
    rst_n = 1'b1;
    tick(1);
    en = 1'b1;
    tick(1);

    // latency: sampled at edge N, counted at N+SS
    pulse[0] = 1'b1;
    tick(1);
    chk("lat_n", 64'(ch_cnt(0)), 64'(0));
    tick(1);
    chk("lat_n1", 64'(ch_cnt(0)), 64'(0));
    tick(1);
    chk("lat_n2", 64'(ch_cnt(0)), 64'(1));
    tick(1);
    pulse[0] = 1'b0;
    tick(2);
    pulses(0, 4);
    chk("rise_ch0", 64'(ch_cnt(0)), 64'(5));
    chk("rise_others", 64'(cnt[CH*W-1:W]), 64'(0));

    // both edges then falling on ch2
    edge_mode = 2'b10;
    pulses(2, 3);
    chk("both_ch2", 64'(ch_cnt(2)), 64'(6));
    edge_mode = 2'b01;
    pulses(2, 3);
    chk("fall_ch2", 64'(ch_cnt(2)), 64'(9));

    // enable gating and no false edge on enable
    edge_mode = 2'b00;
    en = 1'b0;
    pulses(3, 4);
    chk("en0_hold", 64'(ch_cnt(3)), 64'(0));
    pulse[3] = 1'b1;
    tick(SS + 3);
    en = 1'b1;
    tick(4);
    chk("en1_no_spur", 64'(ch_cnt(3)), 64'(0));
    pulse[3] = 1'b0;
    tick(SS + 2);
    edge_mode = 2'b11;
    pulses(3, 2);
    chk("mode11_hold", 64'(ch_cnt(3)), 64'(0));
    edge_mode = 2'b00;
    chk("hold_ch0", 64'(ch_cnt(0)), 64'(5));

    // overflow: wrap then saturate on ch1
    sat_en = 1'b0;
    pulses(1, 17);
    chk("wrap_cnt", 64'(ch_cnt(1)), 64'(1));
    chk("wrap_ovf", 64'(ovf), 64'(4'b0010));
    sat_en = 1'b1;
    pulses(1, 17);
    chk("sat_cnt", 64'(ch_cnt(1)), 64'(15));
    chk("sat_ovf", 64'(ovf), 64'(4'b0010));
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_cnt", 64'(cnt), 64'(0));
    chk("clr_ovf", 64'(ovf), 64'(0));
    sat_en = 1'b0;

    // snapshot coinciding with an increment
    pulses(1, 7);
    chk("pre_snap_ch1", 64'(ch_cnt(1)), 64'(7));
    pulse[1] = 1'b1;
    tick(2);
    snap = 1'b1;
    exp_q.push_back(16'h0080);
    tick(1);
    snap = 1'b0;
    snap_check("snap_edge");
    chk("snap_live_ch1", 64'(ch_cnt(1)), 64'(8));
    tick(1);
    chk("snap_vld_1cyc", 64'(snap_vld), 64'(0));
    pulse[1] = 1'b0;
    tick(SS + 2);

    // back-to-back requests
    snap = 1'b1;
    exp_q.push_back(16'h0080);
    tick(1);
    exp_q.push_back(16'h0080);
    snap_check("snap_b2b_a");
    tick(1);
    snap = 1'b0;
    snap_check("snap_b2b_b");
    tick(1);
    chk("snap_b2b_end", 64'(snap_vld), 64'(0));

    // snap with clr captures zero; snap_cnt then survives clr
    clr = 1'b1;
    snap = 1'b1;
    exp_q.push_back(16'h0000);
    tick(1);
    clr = 1'b0;
    snap = 1'b0;
    snap_check("snap_clr");
    chk("snap_clr_live", 64'(cnt), 64'(0));
    pulses(0, 2);
    snap = 1'b1;
    exp_q.push_back(16'h0002);
    tick(1);
    snap = 1'b0;
    snap_check("snap_ch0");
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("snap_hold_clr", 64'(snap_cnt), 64'(16'h0002));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

`ifdef PULSE_CNT_THRESH_EN
    thresh = 4'd3;
    pulses(0, 2);
    chk("irq_below", 64'(irq), 64'(0));
    pulses(0, 1);
    chk("irq_at3", 64'(irq), 64'(4'b0001));
    pulses(0, 1);
    chk("irq_sticky_cnt", 64'(ch_cnt(0)), 64'(4));
    chk("irq_sticky", 64'(irq), 64'(4'b0001));
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("irq_clr", 64'(irq), 64'(0));
`endif

    // reset mid-count with pulse held high
    pulses(2, 3);
    sat_en = 1'b0;
    pulse[0] = 1'b1;
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cnt", 64'(cnt), 64'(0));
    chk("rst_mid_snap", 64'(snap_cnt), 64'(0));
    chk("rst_mid_ovf", 64'(ovf), 64'(0));
    tick(2);
    rst_n = 1'b1;
    tick(SS + 2);
    chk("rst_release_edge", 64'(ch_cnt(0)), 64'(1));
    pulse[0] = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
